// File: rtl/tmr_counter_ctrl.sv
// Run controller for the triple-modular-redundant counter datapath: sequences
// clear/enable for a commanded run length and tracks per-replica fault health.
module tmr_counter_ctrl #(
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 8,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    input  logic             fault_1,
    input  logic             fault_2,
    input  logic             fault_3,
    output logic             ctr_clr,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       failed,
    output logic [CNT_W-1:0] fault_cnt_1,
    output logic [CNT_W-1:0] fault_cnt_2,
    output logic [CNT_W-1:0] fault_cnt_3
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    // True when at least two of the three replica flags are set.
    function automatic logic two_or_more(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    logic [2:0]                  state_r, state_s;
    logic [LEN_W-1:0]            rem_r, rem_s;
    logic                        err_r, err_s;
    logic [2:0]                  failed_r, failed_s;
    logic [2:0][CNT_W-1:0]       cnt_r, cnt_s;
    logic [2:0][CNT_W-1:0]       streak_r, streak_s;
    logic [2:0]                  fault_s;
    logic                        unmask_s;
    logic                        ctr_clr_r, enable_r, busy_r, done_r;

    assign fault_s = {fault_3, fault_2, fault_1};

    // Next-state, run-length and fault-statistics computation.
    always_comb begin
        state_s  = state_r;
        rem_s    = rem_r;
        err_s    = err_r;
        failed_s = failed_r;
        cnt_s    = cnt_r;
        streak_s = streak_r;
        unmask_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rem_s    = cmd_len;
                    err_s    = 1'b0;
                    failed_s = 3'b000;
                    cnt_s    = {3{CNT_ZERO}};
                    streak_s = {3{CNT_ZERO}};
                    state_s  = (cmd_len != LEN_ZERO) ? ST_CLEAR : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_s = ST_RUN;
            ST_RUN: begin
                for (int i = 0; i < 3; i++) begin
                    if (fault_s[i]) begin
                        cnt_s[i]    = (cnt_r[i] != CNT_MAX) ? cnt_r[i] + CNT_ONE : cnt_r[i];
                        // Streak stops at PERSIST so it cannot wrap on long faults.
                        streak_s[i] = (streak_r[i] != PERSIST_C) ? streak_r[i] + CNT_ONE : streak_r[i];
                        failed_s[i] = failed_r[i] | (streak_s[i] == PERSIST_C);
                    end else begin
                        streak_s[i] = CNT_ZERO;
                        failed_s[i] = failed_r[i];
                    end
                end
                rem_s    = rem_r - LEN_ONE;
                unmask_s = (&fault_s) | two_or_more(failed_s);
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (unmask_s) begin
                    state_s = ST_ERROR;
                    err_s   = 1'b1;
                end else if (rem_r == LEN_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERROR: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ERROR;
                end
            end
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, statistics and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            rem_r     <= LEN_ZERO;
            err_r     <= 1'b0;
            failed_r  <= 3'b000;
            cnt_r     <= {3{CNT_ZERO}};
            streak_r  <= {3{CNT_ZERO}};
            ctr_clr_r <= 1'b0;
            enable_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            rem_r     <= rem_s;
            err_r     <= err_s;
            failed_r  <= failed_s;
            cnt_r     <= cnt_s;
            streak_r  <= streak_s;
            ctr_clr_r <= (state_s == ST_CLEAR);
            enable_r  <= (state_s == ST_RUN);
            busy_r    <= (state_s == ST_CLEAR) | (state_s == ST_RUN) | (state_s == ST_DONE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign cmd_ready   = (state_r == ST_IDLE);
    assign ctr_clr     = ctr_clr_r;
    assign enable      = enable_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign failed      = failed_r;
    assign fault_cnt_1 = cnt_r[0];
    assign fault_cnt_2 = cnt_r[1];
    assign fault_cnt_3 = cnt_r[2];

endmodule

// File: tb/tb_tmr_counter_ctrl.sv
// Self-checking bench for tmr_counter_ctrl: cycle-level reference model plus
// directed run scenarios with hand-computed expectations.
module tb_tmr_counter_ctrl;

    localparam int LEN_W   = 16;
    localparam int CNT_W   = 4;
    localparam int PERSIST = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_CLEAR = 3'd1;
    localparam logic [2:0] M_RUN   = 3'd2;
    localparam logic [2:0] M_DONE  = 3'd3;
    localparam logic [2:0] M_ERR   = 3'd4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, abort;
    logic [LEN_W-1:0] cmd_len;
    logic             fault_1, fault_2, fault_3;
    logic             ctr_clr, enable, busy, done, err;
    logic [2:0]       failed;
    logic [CNT_W-1:0] fault_cnt_1, fault_cnt_2, fault_cnt_3;

    int n_chk  = 0;
    int n_fail = 0;

    tmr_counter_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W), .PERSIST(PERSIST)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .abort(abort), .fault_1(fault_1), .fault_2(fault_2),
        .fault_3(fault_3), .ctr_clr(ctr_clr), .enable(enable), .busy(busy),
        .done(done), .err(err), .failed(failed), .fault_cnt_1(fault_cnt_1),
        .fault_cnt_2(fault_cnt_2), .fault_cnt_3(fault_cnt_3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       ph;
        int               left;
        logic [2:0][31:0] cnt;
        logic [2:0][31:0] streak;
        logic [2:0]       fl;
        logic             er;
    } mdl_t;

    mdl_t m;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: one clock edge of the controller.
    function automatic mdl_t step(input mdl_t cur, input logic v, input logic [15:0] len,
                                  input logic ab, input logic [2:0] f);
        mdl_t n;
        n = cur;
        case (cur.ph)
            M_IDLE: begin
                if (v) begin
                    n.cnt    = '0;
                    n.streak = '0;
                    n.fl     = 3'b000;
                    n.er     = 1'b0;
                    n.left   = int'(len);
                    n.ph     = (len == 16'd0) ? M_DONE : M_CLEAR;
                end
            end
            M_CLEAR: n.ph = M_RUN;
            M_RUN: begin
                for (int i = 0; i < 3; i++) begin
                    if (f[i]) begin
                        n.cnt[i]    = (cur.cnt[i] < CMAX) ? cur.cnt[i] + 1 : CMAX;
                        n.streak[i] = cur.streak[i] + 1;
                        if (n.streak[i] >= PERSIST) n.fl[i] = 1'b1;
                    end else begin
                        n.streak[i] = 0;
                    end
                end
                n.left = cur.left - 1;
                if (ab) n.ph = M_IDLE;
                else if (f == 3'b111 || $countones(n.fl) >= 2) begin
                    n.ph = M_ERR;
                    n.er = 1'b1;
                end else if (n.left == 0) n.ph = M_DONE;
            end
            M_DONE: n.ph = M_IDLE;
            M_ERR:  if (ab) n.ph = M_IDLE;
            default: n.ph = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= step(m, cmd_valid, cmd_len, abort, {fault_3, fault_2, fault_1});
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m.ph == M_IDLE));
            check("ctr_clr",   32'(ctr_clr),   32'(m.ph == M_CLEAR));
            check("enable",    32'(enable),    32'(m.ph == M_RUN));
            check("busy",      32'(busy),      32'(m.ph == M_CLEAR || m.ph == M_RUN || m.ph == M_DONE));
            check("done",      32'(done),      32'(m.ph == M_DONE));
            check("err",       32'(err),       32'(m.er));
            check("failed",    32'(failed),    32'(m.fl));
            check("cnt1",      32'(fault_cnt_1), m.cnt[0]);
            check("cnt2",      32'(fault_cnt_2), m.cnt[1]);
            check("cnt3",      32'(fault_cnt_3), m.cnt[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pat(input int mode, input int k);
        case (mode)
            1:       return (k < 2) ? 3'b010 : 3'b000;
            2:       return (k < 6) ? 3'b001 : 3'b000;
            3:       return (k == 3) ? 3'b111 : 3'b000;
            4:       return (k < 40 && (k % 2) == 0) ? 3'b100 : 3'b000;
            5:       return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Accept a command and follow it until the controller leaves busy.
    task automatic drive_run(input int len, input int mode,
                             output int en, output int clr, output int dn, output int bz);
        int k;
        logic fin;
        en = 0; clr = 0; dn = 0; bz = 0; k = 0; fin = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = 16'(len);
        tick();
        cmd_valid = 1'b0;
        for (int t = 0; t < 300; t++) begin
            en  += int'(enable);
            clr += int'(ctr_clr);
            dn  += int'(done);
            bz  += int'(busy);
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            {fault_3, fault_2, fault_1} = enable ? pat(mode, k) : 3'b000;
            abort = (mode == 4) && enable && (k == 45);
            if (enable) k++;
            tick();
        end
        {fault_3, fault_2, fault_1} = 3'b000;
        abort = 1'b0;
        check("run_terminates", 32'(fin), 32'd1);
    endtask

    int en, clr, dn, bz;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_len = 16'd0; abort = 1'b0;
        fault_1 = 1'b0; fault_2 = 1'b0; fault_3 = 1'b0;
        #3;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_enable",    32'(enable),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_failed",    32'(failed),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        drive_run(5, 0, en, clr, dn, bz);
        check("t1_enable_cycles", en, 5);
        check("t1_clr_cycles", clr, 1);
        check("t1_done_pulses", dn, 1);
        check("t1_busy_cycles", bz, 7);

        drive_run(0, 0, en, clr, dn, bz);
        check("t2_enable_cycles", en, 0);
        check("t2_clr_cycles", clr, 0);
        check("t2_done_pulses", dn, 1);
        check("t2_busy_cycles", bz, 1);

        drive_run(20, 1, en, clr, dn, bz);
        check("t3_enable_cycles", en, 20);
        check("t3_done_pulses", dn, 1);
        check("t3_cnt2", 32'(fault_cnt_2), 32'd2);
        check("t3_failed", 32'(failed), 32'd0);

        drive_run(10, 2, en, clr, dn, bz);
        check("t4_enable_cycles", en, 10);
        check("t4_done_pulses", dn, 1);
        check("t4_cnt1", 32'(fault_cnt_1), 32'd6);
        check("t4_failed", 32'(failed), 32'b001);
        check("t4_err", 32'(err), 32'd0);

        drive_run(10, 3, en, clr, dn, bz);
        check("t5_enable_cycles", en, 4);
        check("t5_done_pulses", dn, 0);
        check("t5_err", 32'(err), 32'd1);
        check("t5_cnt3", 32'(fault_cnt_3), 32'd1);
        cmd_valid = 1'b1; cmd_len = 16'd3;
        tick(); tick();
        check("t5_cmd_ignored", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_idle", 32'(cmd_ready), 32'd1);
        check("t5_err_kept", 32'(err), 32'd1);

        drive_run(0, 0, en, clr, dn, bz);
        check("t6_err_cleared", 32'(err), 32'd0);
        check("t6_done_pulses", dn, 1);

        drive_run(20, 5, en, clr, dn, bz);
        check("t7_enable_cycles", en, 4);
        check("t7_failed", 32'(failed), 32'b011);
        check("t7_err", 32'(err), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        drive_run(60, 4, en, clr, dn, bz);
        check("t8_enable_cycles", en, 46);
        check("t8_done_pulses", dn, 0);
        check("t8_cnt3_sat", 32'(fault_cnt_3), 32'd15);
        check("t8_failed", 32'(failed), 32'd0);
        drive_run(2, 0, en, clr, dn, bz);
        check("t8_next_enable", en, 2);
        check("t8_next_done", dn, 1);

        cmd_valid = 1'b1; cmd_len = 16'd10;
        tick();
        cmd_valid = 1'b0;
        fault_1 = 1'b1;
        tick(); tick(); tick();
        fault_1 = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t9_enable_async", 32'(enable), 32'd0);
        check("t9_clr_async", 32'(ctr_clr), 32'd0);
        check("t9_cnt1_lost", 32'(fault_cnt_1), 32'd0);
        check("t9_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_counter_ctrl.md
Name: tmr_counter_ctrl

Overview:
Run controller for the triple-modular-redundant counter datapath (three counter replicas plus majority voter). Accepts a run command over a valid/ready handshake, clears the datapath, and drives the shared count enable for exactly the commanded number of cycles. While the run is active it monitors the three per-replica fault flags. It keeps per-replica fault statistics, marks persistently faulty replicas as failed, and stops the run on an unmaskable fault condition.

Parameters:
LEN_W, 16, width of the run-length command (max run 2^LEN_W-1 enable cycles)
CNT_W, 8, width of each per-replica saturating fault counter
PERSIST, 4, consecutive faulted RUN cycles before a replica is marked failed (1 <= PERSIST <= 2^CNT_W-1)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
cmd_valid  in  1  run command valid
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_len  in  LEN_W  number of enable cycles for the run; sampled on accept
abort  in  1  terminate RUN or ERROR, return to IDLE
fault_1/fault_2/fault_3  in  1  replica N disagrees with the voted value (from datapath)
ctr_clr  out  1  synchronous clear request to all three counter replicas
enable  out  1  shared count enable to all three replicas
busy  out  1  high in CLEAR, RUN and DONE
done  out  1  one-cycle pulse when a run completes normally
err  out  1  sticky error: unmaskable fault seen
failed  out  3  sticky per-replica failed flags; bit0 corresponds to replica 1
fault_cnt_1/_2/_3  out  CNT_W  saturating count of faulted RUN cycles per replica

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. ctr_clr, enable, busy, done and err are 0. failed and all counters are 0. cmd_ready=1.
- All outputs are registered, except cmd_ready, which is decoded from the state (1 iff IDLE).
- States: IDLE, CLEAR, RUN, DONE, ERROR.
- IDLE: on cmd_valid&cmd_ready:
  - Latch cmd_len into the remaining-count register.
  - Clear err, failed, fault_cnt_* and the consecutive counters.
  - Go to CLEAR if cmd_len!=0, else go to DONE (zero-length run: done pulse, no enable, no ctr_clr).
- CLEAR: ctr_clr=1 for exactly one cycle, then go to RUN.
- RUN: enable=1 every cycle spent in RUN. remaining decrements by 1 each RUN cycle. On the cycle remaining==1, go to DONE, so enable is high exactly cmd_len consecutive cycles.
- Fault sampling: fault_i is sampled only in RUN cycles; it is ignored in all other states.
  - Each sampled fault_i=1 increments fault_cnt_i, saturating at 2^CNT_W-1 (no wrap).
  - The per-replica consecutive counter increments on fault_i=1 and clears on fault_i=0. When it reaches PERSIST, failed[i] is set and stays set until the next accepted command.
- Unmaskable condition, evaluated on the same sampled values: all three fault_i=1 in one cycle, OR two or more bits of the next-cycle failed vector set. Response:
  - Go to ERROR and set err=1 on the next edge.
  - enable drops on that edge; the run is not completed and no done pulse is issued.
- Priority within RUN: abort > unmaskable condition > normal completion. abort in RUN goes to IDLE next cycle with no done pulse; counters and flags are preserved for readback.
- DONE: done=1 for one cycle, then go to IDLE.
- ERROR: enable=0. Held until abort=1, then go to IDLE. err, failed and counters are preserved.
- busy=1 in CLEAR, RUN and DONE; busy=0 in IDLE and ERROR.
- cmd_valid outside IDLE is ignored. A command is consumed only on a valid&ready cycle.
- Reset mid-run: enable and ctr_clr drop immediately (asynchronously). All statistics are lost.

Test Plan:
- Normal run: reset, then cmd_len=5 -> ctr_clr high 1 cycle, then enable high exactly 5 cycles, done pulse on the following cycle, cmd_ready back to 1; datapath output reads 5.
- Zero length: cmd_len=0 -> no ctr_clr, no enable, done pulse 1 cycle after accept, busy high 1 cycle.
- Transient single fault: cmd_len=20, force fault_2=1 for 2 RUN cycles (PERSIST=4) -> fault_cnt_2=2, failed=000, err=0, done pulse, enable high 20 cycles total.
- Persistent fault: hold fault_1=1 for 6 RUN cycles -> failed[0] set after 4th faulted cycle, fault_cnt_1=6, run completes with done and err=0.
- Unmaskable: in RUN assert fault_1=fault_2=fault_3=1 in one cycle -> next edge state ERROR, enable=0, err=1, no done. abort -> IDLE, err still 1 until next command accepted, where it clears.
- Abort and saturation: CNT_W=4, fault_3 toggling 1/0 for 40 RUN cycles -> fault_cnt_3 saturates at 15, failed=000. abort mid-run -> enable low next cycle, no done, new command accepted the following cycle.
